// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StDrop,
    StHalt
  } fetch_state_e;

  localparam logic [31:0] Nop            = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] PcIncr         = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word that decode could not accept.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_take,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_valid <= 1'b0;
      r_entry <= '{pc: 32'h0, instr: Nop, misalign: 1'b0};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_take) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake and IF/ID register.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets instead of masking them.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_misalign
);

  fetch_state_e r_state, w_state_next;
  logic [31:0]  r_pc, w_pc_next;
  logic         r_id_valid, r_id_misalign;
  logic [31:0]  r_id_pc, r_id_instr;

  logic         w_skid_valid, w_skid_load, w_skid_take;
  fetch_entry_t w_skid_entry, w_rsp_entry;
  logic         w_rsp_take, w_id_load;
  logic [31:0]  w_target;
  logic         w_misalign_redir;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_target         = redirect_pc;
  assign w_misalign_redir = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  logic w_unused_rpc_lsb;
  assign w_unused_rpc_lsb = ^redirect_pc[1:0];
  assign w_target         = {redirect_pc[31:2], 2'b00};
  assign w_misalign_redir = 1'b0;
`endif

  // Request suppressed while redirecting so no fetch to the stale PC gets accepted.
  assign imem_req_valid = (r_state == StReq) && !w_skid_valid && !rst && !redirect_valid;
  assign imem_addr      = r_pc;

  assign w_rsp_take  = (r_state == StWait) && imem_rsp_valid && !redirect_valid;
  assign w_id_load   = !stall || !r_id_valid;
  assign w_skid_load = w_rsp_take && !w_id_load;
  assign w_skid_take = w_skid_valid && !stall && !redirect_valid;
  assign w_rsp_entry = '{pc: r_pc, instr: imem_rsp_data, misalign: 1'b0};

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_take  (w_skid_take),
    .i_clear (redirect_valid),
    .i_entry (w_rsp_entry),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_entry)
  );

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    if (redirect_valid) begin
      w_pc_next = w_target;
      if (w_misalign_redir) begin
        w_state_next = StHalt;
      end else if ((r_state == StWait || r_state == StDrop) && !imem_rsp_valid) begin
        w_state_next = StDrop;
      end else begin
        w_state_next = StReq;
      end
    end else begin
      case (r_state)
        StReq: begin
          if (imem_req_valid && imem_req_ready) w_state_next = StWait;
        end
        StWait: begin
          if (imem_rsp_valid) begin
            w_state_next = StReq;
            w_pc_next    = r_pc + PcIncr;
          end
        end
        StDrop: begin
          if (imem_rsp_valid) w_state_next = StReq;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StReq;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_valid    <= 1'b0;
      r_id_pc       <= 32'h0;
      r_id_instr    <= Nop;
      r_id_misalign <= 1'b0;
    end else if (redirect_valid) begin
      // A misaligned target becomes a marker instruction instead of a fetch.
      r_id_valid    <= w_misalign_redir;
      r_id_misalign <= w_misalign_redir;
      if (w_misalign_redir) begin
        r_id_pc    <= w_target;
        r_id_instr <= Nop;
      end
    end else if (w_id_load) begin
      if (w_skid_valid) begin
        r_id_valid    <= 1'b1;
        r_id_pc       <= w_skid_entry.pc;
        r_id_instr    <= w_skid_entry.instr;
        r_id_misalign <= w_skid_entry.misalign;
      end else if (w_rsp_take) begin
        r_id_valid    <= 1'b1;
        r_id_pc       <= w_rsp_entry.pc;
        r_id_instr    <= w_rsp_entry.instr;
        r_id_misalign <= w_rsp_entry.misalign;
      end else begin
        r_id_valid    <= 1'b0;
        r_id_misalign <= 1'b0;
      end
    end
  end

  assign id_valid    = r_id_valid;
  assign id_pc       = r_id_pc;
  assign id_instr    = r_id_instr;
  assign id_misalign = r_id_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle vectors for fetch_stage; inputs set at negedge, outputs sampled 1ns later.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] A0   = 32'h0010_0093;
  localparam logic [31:0] A4   = 32'h0020_0113;
  localparam logic [31:0] A8   = 32'h0030_0193;
  localparam logic [31:0] A12  = 32'h0040_0213;
  localparam logic [31:0] B100 = 32'h0050_0293;
  localparam logic [31:0] CFFC = 32'h0060_0313;
  localparam logic [31:0] D0   = 32'h0070_0393;
  localparam logic [31:0] E0   = 32'h0080_0413;
  localparam logic [31:0] BAD1 = 32'hBADB_AD01;
  localparam logic [31:0] BAD2 = 32'hBADB_AD02;
  localparam logic [31:0] BAD3 = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_misalign;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_misalign    (id_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        stall, rdy, rsv;
    logic [31:0] rdata;
    logic        rqv;
    logic [31:0] addr;
    logic        idv, chk;
    logic [31:0] idpc, idinstr;
    logic        mis;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(input int rst_i, input int rv, input logic [31:0] rpc,
                              input int stl, input int rdy, input int rsv,
                              input logic [31:0] rdata, input int rqv,
                              input logic [31:0] addr, input int idv, input int chk,
                              input logic [31:0] idpc, input logic [31:0] ii, input int mis);
    vec_t v;
    v.rst = (rst_i != 0); v.rv = (rv != 0); v.rpc = rpc;
    v.stall = (stl != 0); v.rdy = (rdy != 0); v.rsv = (rsv != 0); v.rdata = rdata;
    v.rqv = (rqv != 0); v.addr = addr; v.idv = (idv != 0); v.chk = (chk != 0);
    v.idpc = idpc; v.idinstr = ii; v.mis = (mis != 0);
    return v;
  endfunction

  task automatic chk32(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    rst            = v.rst;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    stall          = v.stall;
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rsv;
    imem_rsp_data  = v.rdata;
    #1;
    chk32("imem_req_valid", idx, {31'h0, imem_req_valid}, {31'h0, v.rqv});
    chk32("imem_addr", idx, imem_addr, v.addr);
    chk32("id_valid", idx, {31'h0, id_valid}, {31'h0, v.idv});
    chk32("id_misalign", idx, {31'h0, id_misalign}, {31'h0, v.mis});
    if (v.chk) begin
      chk32("id_pc", idx, id_pc, v.idpc);
      chk32("id_instr", idx, id_instr, v.idinstr);
    end
  endtask

  initial begin
    //            rst rv rpc          st rdy rsv rdata  rqv addr         idv chk idpc ... mis
    vecs[0]  = mk(1, 0, 0,            0, 0, 0, 0,    0, 0,            0, 1, 0, NOP, 0);
    vecs[1]  = mk(0, 0, 0,            0, 1, 0, 0,    1, 0,            0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0, 1, A0,   0, 0,            0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,            0, 1, 0, 0,    1, 4,            1, 1, 0, A0, 0);
    vecs[4]  = mk(0, 0, 0,            0, 0, 1, A4,   0, 4,            0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,            0, 1, 0, 0,    1, 8,            1, 1, 4, A4, 0);
    vecs[6]  = mk(0, 0, 0,            0, 0, 1, A8,   0, 8,            0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0,            1, 1, 0, 0,    1, 12,           1, 1, 8, A8, 0);
    vecs[8]  = mk(0, 0, 0,            1, 0, 1, A12,  0, 12,           1, 1, 8, A8, 0);
    vecs[9]  = mk(0, 0, 0,            1, 1, 0, 0,    0, 16,           1, 1, 8, A8, 0);
    vecs[10] = mk(0, 0, 0,            1, 1, 0, 0,    0, 16,           1, 1, 8, A8, 0);
    vecs[11] = mk(0, 0, 0,            0, 1, 0, 0,    0, 16,           1, 1, 8, A8, 0);
    vecs[12] = mk(0, 0, 0,            0, 1, 0, 0,    1, 16,           1, 1, 12, A12, 0);
    vecs[13] = mk(0, 1, 32'h100,      0, 0, 0, 0,    0, 16,           0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0,            0, 1, 1, BAD1, 0, 32'h100,      0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0,            0, 1, 0, 0,    1, 32'h100,      0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0,            0, 0, 1, B100, 0, 32'h100,      0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0,            0, 1, 0, 0,    1, 32'h104,      1, 1, 32'h100, B100, 0);
    vecs[18] = mk(0, 1, 32'hFFFFFFFC, 0, 0, 1, BAD2, 0, 32'h104,      0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0,            0, 1, 0, 0,    1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    vecs[20] = mk(0, 0, 0,            0, 0, 1, CFFC, 0, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0,            0, 0, 0, 0,    1, 0,            1, 1, 32'hFFFFFFFC, CFFC, 0);
    vecs[22] = mk(0, 0, 0,            0, 1, 0, 0,    1, 0,            0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0,            0, 0, 1, D0,   0, 0,            0, 0, 0, 0, 0);
    vecs[24] = mk(0, 1, 32'h200,      0, 1, 0, 0,    0, 4,            1, 1, 0, D0, 0);
    vecs[25] = mk(0, 0, 0,            0, 1, 0, 0,    1, 32'h200,      0, 0, 0, 0, 0);

    for (int i = 0; i < 26; i++) run_vec(vecs[i], i);

    // Reset while a fetch is outstanding; a late response must be ignored.
    run_vec(mk(1, 0, 0, 0, 0, 0, 0,    0, 32'h200, 0, 0, 0, 0, 0), 100);
    run_vec(mk(0, 0, 0, 0, 0, 1, BAD3, 1, 0,       0, 1, 0, NOP, 0), 101);
    run_vec(mk(0, 0, 0, 0, 1, 0, 0,    1, 0,       0, 0, 0, 0, 0), 102);
    run_vec(mk(0, 0, 0, 0, 0, 1, E0,   0, 0,       0, 0, 0, 0, 0), 103);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0,    1, 4,       1, 1, 0, E0, 0), 104);

`ifdef FETCH_MISALIGN_CHK_EN
    run_vec(mk(0, 1, 32'h102, 0, 1, 0, 0, 0, 4,       0, 0, 0, 0, 0), 200);
    run_vec(mk(0, 0, 0,       0, 1, 0, 0, 0, 32'h102, 1, 1, 32'h102, NOP, 1), 201);
    run_vec(mk(0, 0, 0,       0, 1, 0, 0, 0, 32'h102, 0, 0, 0, 0, 0), 202);
    run_vec(mk(0, 0, 0,       0, 1, 0, 0, 0, 32'h102, 0, 0, 0, 0, 0), 203);
    run_vec(mk(0, 1, 32'h200, 0, 1, 0, 0, 0, 32'h102, 0, 0, 0, 0, 0), 204);
    run_vec(mk(0, 0, 0,       0, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 0), 205);
`else
    // Low target bits are masked when the misalignment trap is not built in.
    run_vec(mk(0, 1, 32'h102, 0, 1, 0, 0, 0, 4,       0, 0, 0, 0, 0), 200);
    run_vec(mk(0, 0, 0,       0, 1, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0), 201);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V pipeline CPU. It holds the architectural PC, issues word fetches to instruction memory over a valid/ready handshake, and presents fetched instructions to decode through the IF/ID register. It consumes the redirect target produced by the next-address unit (`nextPC`) whenever a jump or taken branch resolves. Sequential PC increment (+4) happens here; a redirect overrides it.

## Interface
- `RESET_PC`, 32'h00000000, PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  jump/taken branch resolved this cycle.
- `redirect_pc`  in  32  target from next-address unit (`nextPC`).
- `stall`  in  1  decode cannot accept; hold IF/ID register.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_addr`  out  32  fetch address, equals internal PC.
- `imem_rsp_valid`  in  1  instruction word returned (one cycle wide, never earlier than cycle after accept).
- `imem_rsp_data`  in  32  instruction word.
- `id_valid`  out  1  IF/ID holds a live instruction.
- `id_pc`  out  32  PC of that instruction.
- `id_instr`  out  32  instruction word.
- `id_misalign`  out  1  instruction-address-misaligned marker.

## Operation
- At most one outstanding fetch. States: `REQ` (drive `imem_req_valid`, `imem_addr`=pc_q), `WAIT` (accepted, awaiting response), `DROP` (accepted, response to be discarded), `HALT` (misaligned target, see Configuration).
- `REQ`: request issued only if skid buffer empty; on `imem_req_ready` -> `WAIT`.
- `WAIT` + `imem_rsp_valid`: word+pc_q go to IF/ID if IF/ID empty or `!stall`, else into one-entry skid buffer; pc_q <= pc_q+4 (mod 2^32, wraps 32'hFFFFFFFC -> 0); -> `REQ`.
- IF/ID advance rule: when `!stall`, IF/ID loads skid entry if present, else a same-cycle response, else `id_valid`<=0. When `stall`, IF/ID holds.
- Redirect (highest priority, any state): pc_q <= `redirect_pc`; `id_valid`<=0; skid cleared; from `WAIT` with no response this cycle -> `DROP`; all other cases -> `REQ` (a response arriving in the redirect cycle is discarded). Redirect overrides `stall` for the flush.
- `DROP` + `imem_rsp_valid`: discard, -> `REQ`. Redirect in `DROP` stays `DROP` with new pc_q.
- `imem_req_valid` may not drop once raised until accepted, except on redirect or reset.

## Timing
- Reset values: pc_q=`RESET_PC`, state=`REQ`, `imem_req_valid`=0 during reset cycle, `id_valid`=0, `id_pc`=0, `id_instr`=32'h00000013 (NOP), `id_misalign`=0, skid empty.
- Redirect at cycle t, memory ready and 1-cycle response: request at t+1, response t+2, `id_valid` with `id_pc`=target at t+3.
- Steady-state throughput: one instruction per 2 cycles (single outstanding request).
- Reset mid-operation discards outstanding fetch; late responses after reset are ignored until first request is accepted.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined: redirect with `redirect_pc[1:0]!=0` -> no fetch; next cycle IF/ID loads `id_valid`=1, `id_pc`=target, `id_instr`=NOP, `id_misalign`=1; state `HALT` (no requests) until next redirect.
- Undefined: `redirect_pc[1:0]` forced to 0; `HALT` unreachable; `id_misalign` tied 0.

## Structure
- Shared package: state enum (`REQ`,`WAIT`,`DROP`,`HALT`), NOP constant 32'h00000013, default reset PC, PC increment constant 4.
- Sub-module `fetch_skid_buf`: one-entry {pc, instr, misalign} buffer with load/take/clear.

## Test plan
- Reset, memory always ready, 1-cycle rsp -> `id_pc` sequence 0,4,8 with matching words, `id_valid` on every other cycle.
- `stall` held 4 cycles while response lands -> word captured in skid, no new request, released in order after stall drops, nothing lost or duplicated.
- Redirect to 32'h00000100 while in `WAIT` -> stale response dropped, next `id_pc`=0x100, `id_valid` low at t+1.
- Redirect same cycle as response -> response discarded, fetch from target.
- pc_q=32'hFFFFFFFC sequential -> next fetch address 0.
- With `FETCH_MISALIGN_CHK_EN`, redirect to 32'h00000102 -> `id_misalign`=1, `id_pc`=0x102, no `imem_req_valid` until redirect to 0x200.
